prio_req_serializer: RTL and testbench

Parametrised successor to the 8-to-3 priority encoder. Latches one-cycle request pulses from N sources into a pending register and presents them one at a time, highest priority first, over a valid/ready handshake. Also reports pending count, an any-pending flag and a sticky lost-request flag. Sits between NVBOARD button/switch inputs (or peripheral event lines) and a consumer that services one event per handshake.

---
 rtl/prio_req_serializer.sv | 88 ++++++++
 tb/tb_prio_req_serializer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_req_serializer.sv
// Priority request serializer: latches request pulses and presents them
// one index per valid/ready handshake, with pending count and lost flag.
module prio_req_serializer #(
    parameter int N         = 8,
    parameter int W         = $clog2(N),
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clr,
    input  logic [N-1:0]           req,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [W-1:0]           out_idx,
    output logic                   any,
    output logic [$clog2(N+1)-1:0] count,
    output logic                   lost
);

    localparam int CW = $clog2(N+1);

    logic [N-1:0]  pend;
    logic [N-1:0]  pend_next;
    logic [N-1:0]  clear_mask;
    logic [W-1:0]  sel;
    logic          fire;
    logic          lost_next;
    logic [CW-1:0] cnt;

    // Later loop iterations overwrite earlier hits, so the loop direction
    // decides which end of the vector wins.
    always_comb begin
        sel = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i]) sel = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (pend[i]) sel = W'(i);
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(pend[i]);
        end
    end

    assign any       = |pend;
    assign count     = cnt;
    assign out_valid = en & any;
    assign out_idx   = (en && any) ? sel : '0;
    assign fire      = out_valid & out_ready;

    always_comb begin
        clear_mask = '0;
        if (fire) clear_mask[sel] = 1'b1;
    end

    // A re-request on a bit being drained this cycle keeps it set and is
    // not counted as lost.
    always_comb begin
        pend_next = pend;
        lost_next = lost;
        if (clr) begin
            pend_next = '0;
            lost_next = 1'b0;
        end else if (en) begin
            pend_next = (pend & ~clear_mask) | req;
            if (|(req & pend & ~clear_mask)) lost_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
            lost <= 1'b0;
        end else begin
            pend <= pend_next;
            lost <= lost_next;
        end
    end

endmodule

// File: tb/tb_prio_req_serializer.sv
// Directed bench for prio_req_serializer: one MSB-first and one
// LSB-first instance share stimulus; each task checks its own scenario.
module tb_prio_req_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       clr;
    logic [7:0] req;
    logic       out_ready;

    logic       mv, lv;
    logic [2:0] mi, li;
    logic       ma, la;
    logic [3:0] mc, lc;
    logic       ml, ll;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prio_req_serializer #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
        .out_ready(out_ready), .out_valid(mv), .out_idx(mi),
        .any(ma), .count(mc), .lost(ml)
    );

    prio_req_serializer #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .req(req),
        .out_ready(out_ready), .out_valid(lv), .out_idx(li),
        .any(la), .count(lc), .lost(ll)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        req = '0; out_ready = 1'b0; en = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; clr = 1'b0; out_ready = 1'b1; req = 8'hFF;
        tick(); tick();
        total++;
        if (mv !== 1'b0 || ma !== 1'b0 || mc !== 4'd0 || ml !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: valid=%b any=%b count=%0d lost=%b, need 0/0/0/0",
                     mv, ma, mc, ml);
        end
        rst = 1'b0; req = '0; out_ready = 1'b0;
        tick(); tick();
        total++;
        if (mv !== 1'b0 || mi !== 3'd0 || ma !== 1'b0 || mc !== 4'd0 || ml !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: valid=%b idx=%0d any=%b count=%0d lost=%b, need zeros",
                     mv, mi, ma, mc, ml);
        end
    endtask

    task automatic test_drain();
        logic [2:0] m_seq [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
        logic [2:0] l_seq [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [3:0] c_seq [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
        req = 8'b1010_0101; out_ready = 1'b1;
        tick();
        req = '0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (mv !== 1'b1 || mi !== m_seq[k] || mc !== c_seq[k]) begin
                bad++;
                $display("FAIL drain_msb[%0d]: valid=%b idx=%0d count=%0d, need 1/%0d/%0d",
                         k, mv, mi, mc, m_seq[k], c_seq[k]);
            end
            total++;
            if (lv !== 1'b1 || li !== l_seq[k] || lc !== c_seq[k]) begin
                bad++;
                $display("FAIL drain_lsb[%0d]: valid=%b idx=%0d count=%0d, need 1/%0d/%0d",
                         k, lv, li, lc, l_seq[k], c_seq[k]);
            end
            tick();
        end
        total++;
        if (mv !== 1'b0 || ma !== 1'b0 || lv !== 1'b0 || la !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty: msb valid=%b any=%b lsb valid=%b any=%b, need 0",
                     mv, ma, lv, la);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; req = 8'h10;
        tick();
        req = '0;
        total++;
        if (mv !== 1'b1 || mi !== 3'd4 || mc !== 4'd1 || ml !== 1'b0) begin
            bad++;
            $display("FAIL bp_first: valid=%b idx=%0d count=%0d lost=%b, need 1/4/1/0",
                     mv, mi, mc, ml);
        end
        tick(); tick();
        req = 8'h10;
        tick();
        req = '0;
        total++;
        if (mv !== 1'b1 || mi !== 3'd4 || mc !== 4'd1 || ml !== 1'b1) begin
            bad++;
            $display("FAIL bp_lost: valid=%b idx=%0d count=%0d lost=%b, need 1/4/1/1",
                     mv, mi, mc, ml);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (mv !== 1'b0 || mc !== 4'd0 || ml !== 1'b1) begin
            bad++;
            $display("FAIL bp_fire: valid=%b count=%0d lost=%b, need 0/0/1",
                     mv, mc, ml);
        end
        tick();
        total++;
        if (ml !== 1'b1) begin
            bad++;
            $display("FAIL bp_sticky: lost=%b, need 1", ml);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++;
        if (ml !== 1'b0 || ll !== 1'b0) begin
            bad++;
            $display("FAIL bp_clr: lost msb=%b lsb=%b, need 0/0", ml, ll);
        end
    endtask

    task automatic test_same_cycle();
        req = 8'h08;
        tick();
        req = '0;
        total++;
        if (mv !== 1'b1 || mi !== 3'd3) begin
            bad++;
            $display("FAIL same_setup: valid=%b idx=%0d, need 1/3", mv, mi);
        end
        out_ready = 1'b1; req = 8'h08;
        tick();
        out_ready = 1'b0; req = '0;
        total++;
        if (mv !== 1'b1 || mi !== 3'd3 || mc !== 4'd1 || ml !== 1'b0) begin
            bad++;
            $display("FAIL same_cycle: valid=%b idx=%0d count=%0d lost=%b, need 1/3/1/0",
                     mv, mi, mc, ml);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++;
        if (mv !== 1'b0 || ma !== 1'b0) begin
            bad++;
            $display("FAIL same_drain: valid=%b any=%b, need 0/0", mv, ma);
        end
    endtask

    task automatic test_enable();
        req = 8'h03;
        tick();
        req = '0;
        en = 1'b0; req = 8'h83; out_ready = 1'b1;
        tick();
        req = '0;
        total++;
        if (mv !== 1'b0 || mi !== 3'd0 || ma !== 1'b1 || mc !== 4'd2 || ml !== 1'b0) begin
            bad++;
            $display("FAIL en_gate: valid=%b idx=%0d any=%b count=%0d lost=%b, need 0/0/1/2/0",
                     mv, mi, ma, mc, ml);
        end
        tick();
        total++;
        if (mc !== 4'd2 || lc !== 4'd2) begin
            bad++;
            $display("FAIL en_hold: count msb=%0d lsb=%0d, need 2/2", mc, lc);
        end
        out_ready = 1'b0;
        en = 1'b1;
        #1;
        total++;
        if (mv !== 1'b1 || mi !== 3'd1 || li !== 3'd0) begin
            bad++;
            $display("FAIL en_resume: valid=%b idx msb=%0d lsb=%0d, need 1/1/0",
                     mv, mi, li);
        end
        clean();
    endtask

    task automatic test_full();
        req = 8'hFF;
        tick();
        total++;
        if (mc !== 4'd8 || ma !== 1'b1 || ml !== 1'b0 || mi !== 3'd7 || li !== 3'd0) begin
            bad++;
            $display("FAIL full_count: count=%0d any=%b lost=%b idx=%0d/%0d, need 8/1/0/7/0",
                     mc, ma, ml, mi, li);
        end
        tick();
        req = '0;
        total++;
        if (mc !== 4'd8 || ml !== 1'b1 || ll !== 1'b1) begin
            bad++;
            $display("FAIL full_lost: count=%0d lost=%b/%b, need 8/1/1", mc, ml, ll);
        end
        clr = 1'b1; req = 8'h40;
        tick();
        clr = 1'b0; req = '0;
        total++;
        if (mc !== 4'd0 || ma !== 1'b0 || ml !== 1'b0) begin
            bad++;
            $display("FAIL full_clr: count=%0d any=%b lost=%b, need 0/0/0", mc, ma, ml);
        end
    endtask

    task automatic test_rst_mid();
        req = 8'h22; out_ready = 1'b0;
        tick();
        req = '0; out_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (mv !== 1'b0 || mc !== 4'd0 || ma !== 1'b0 || lv !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: valid=%b count=%0d any=%b lsb valid=%b, need 0/0/0/0",
                     mv, mc, ma, lv);
        end
        tick();
        rst = 1'b0; out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_drain();
        test_backpressure();
        test_same_cycle();
        test_enable();
        test_full();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
